// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions.
//   SEG7_LUT     : active-high gfedcba patterns for digits 0..9, dash at index 10
//   SEG7_DASH_IDX: LUT index of the dash pattern
//   SEG_BLANK    : all segments off (active-high), for blanked display positions
//   seg7_encode  : digit -> segment pattern, dash for anything above 9,
//                  optionally inverted for active-low displays
package seg7_pkg;

    localparam logic [3:0] SEG7_DASH_IDX = 4'd10;
    localparam logic [6:0] SEG_BLANK     = 7'h00;

    // NOTE: a constant ROM like this needs no reset; only state-holding flops do.
    localparam logic [6:0] SEG7_LUT [0:10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
        7'h40
    };

    function automatic logic [6:0] seg7_encode(input logic [3:0] digit,
                                               input logic       active_high);
        logic [6:0] pat;
        if (digit <= 4'd9) pat = SEG7_LUT[digit];
        else               pat = SEG7_LUT[SEG7_DASH_IDX];
        return active_high ? pat : ~pat;
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running prescaler producing a terminal strobe every TICK_DIV enabled cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : 1 = count advances, 0 = count holds
//   clear      : synchronous restart to 0 (wins over enable, never strobes)
//   terminal   : combinational, high in the cycle whose edge ends a period
module seg7_prescaler #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam int              CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_d    = cnt_q;
        terminal = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                terminal = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg7_tick_counter.sv
// Prescaled single-digit decimal up/down counter with registered 7-segment output.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : 1 = prescaler runs, 0 = everything holds
//   up_down    : step direction, sampled only on the terminal edge
//   load       : synchronous load of min(load_val, MAX_DIGIT); beats stepping
//   load_val   : value to load
//   digit      : current digit (registered)
//   segments   : pattern of digit, one edge behind digit; bit0=a .. bit6=g
//   tick       : one-cycle pulse on every step
//   wrap       : one-cycle pulse on a wrapping step
module seg7_tick_counter
    import seg7_pkg::*;
#(
    parameter int TICK_DIV        = 10_000_000,
    parameter int MAX_DIGIT       = 9,
    parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       up_down,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic [6:0] segments,
    output logic       tick,
    output logic       wrap
);

    localparam logic [3:0] MAX_D     = 4'(MAX_DIGIT);
    localparam logic [6:0] SEG_RESET = seg7_encode(4'd0, SEG_ACTIVE_HIGH);

    logic       terminal;
    logic [3:0] digit_q, digit_d;
    logic [6:0] segments_q, segments_d;
    logic       tick_q, tick_d;
    logic       wrap_q, wrap_d;
    logic [3:0] enc_digit;

    // Load doubles as prescaler clear, so a load on the terminal cycle
    // both suppresses the step and restarts the period.
    seg7_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clear    (load),
        .terminal (terminal)
    );

    always_comb begin
        digit_d = digit_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            digit_d = (load_val > MAX_D) ? MAX_D : load_val;
        end else if (terminal) begin
            tick_d = 1'b1;
            if (up_down) begin
                if (digit_q == MAX_D) begin
                    digit_d = 4'd0;
                    wrap_d  = 1'b1;
                end else begin
                    digit_d = digit_q + 4'd1;
                end
            end else begin
                if (digit_q == 4'd0) begin
                    digit_d = MAX_D;
                    wrap_d  = 1'b1;
                end else begin
                    digit_d = digit_q - 4'd1;
                end
            end
        end
    end

    // Segments are looked up from the registered digit, so they trail it by one edge.
    // Out-of-range digits (unreachable) are forced to the dash entry.
    always_comb begin
        enc_digit  = (digit_q > MAX_D) ? 4'd15 : digit_q;
        segments_d = seg7_encode(enc_digit, SEG_ACTIVE_HIGH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q    <= 4'd0;
            segments_q <= SEG_RESET;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            digit_q    <= digit_d;
            segments_q <= segments_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
        end
    end

    assign digit    = digit_q;
    assign segments = segments_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_seg7_tick_counter.sv
// Self-checking bench for seg7_tick_counter: directed steps followed by random
// stimulus, each cycle compared against a behavioural model of the counter.
module tb_seg7_tick_counter;

    localparam int TICK_DIV  = 4;
    localparam int MAX_DIGIT = 9;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] p_digit, n_digit;
    logic [6:0] p_segments, n_segments;
    logic       p_tick, n_tick, p_wrap, n_wrap;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model state: phase counts enabled cycles into the current period.
    int m_phase, m_digit, m_seg_digit;
    bit m_tick, m_wrap;

    logic [6:0] seg_table [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                     7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_tick_counter #(.TICK_DIV(TICK_DIV), .MAX_DIGIT(MAX_DIGIT), .SEG_ACTIVE_HIGH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
        .digit(p_digit), .segments(p_segments), .tick(p_tick), .wrap(p_wrap)
    );

    seg7_tick_counter #(.TICK_DIV(TICK_DIV), .MAX_DIGIT(MAX_DIGIT), .SEG_ACTIVE_HIGH(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val),
        .digit(n_digit), .segments(n_segments), .tick(n_tick), .wrap(n_wrap)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_digit = 0; m_seg_digit = 0; m_tick = 0; m_wrap = 0;
    endtask

    // One clock edge of the specified behaviour, in plain arithmetic.
    task automatic model_edge(input bit en, input bit ud, input bit ld, input int lv);
        m_seg_digit = m_digit;
        m_tick = 0;
        m_wrap = 0;
        if (ld) begin
            m_digit = (lv > MAX_DIGIT) ? MAX_DIGIT : lv;
            m_phase = 0;
        end else if (en) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_tick  = 1;
                if (ud) begin
                    m_digit = (m_digit + 1) % (MAX_DIGIT + 1);
                    m_wrap  = (m_digit == 0);
                end else begin
                    m_wrap  = (m_digit == 0);
                    m_digit = (m_digit + MAX_DIGIT) % (MAX_DIGIT + 1);
                end
            end
        end
    endtask

    task automatic check_model();
        check("digit",      8'(p_digit),    8'(m_digit));
        check("tick",       8'(p_tick),     8'(m_tick));
        check("wrap",       8'(p_wrap),     8'(m_wrap));
        check("segments",   8'(p_segments), 8'(seg_table[m_seg_digit]));
        check("n_digit",    8'(n_digit),    8'(m_digit));
        check("n_tick",     8'(n_tick),     8'(m_tick));
        check("n_wrap",     8'(n_wrap),     8'(m_wrap));
        check("n_segments", 8'(n_segments), 8'(~seg_table[m_seg_digit] & 7'h7F));
    endtask

    task automatic step(input bit en, input bit ud, input bit ld, input logic [3:0] lv);
        enable = en; up_down = ud; load = ld; load_val = lv;
        @(posedge clk);
        #1;
        model_edge(en, ud, ld, int'(lv));
        check_model();
    endtask

    initial begin
        // 1. Reset with the clock stopped, then idle with enable low.
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_digit",    8'(p_digit),    8'h00);
        check("rst_segments", 8'(p_segments), 8'h3F);
        check("rst_tick",     8'(p_tick),     8'h00);
        check("rst_wrap",     8'(p_wrap),     8'h00);
        check("rst_n_segs",   8'(n_segments), 8'h40);
        #2 rst_n = 1'b1;
        #2 clk_run = 1'b1;
        repeat (20) step(1'b0, 1'b1, 1'b0, 4'd0);
        check("idle_segments", 8'(p_segments), 8'h3F);

        // 2. Count up from reset: first tick on the 4th edge.
        repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);
        check("first_tick_pre", 8'(p_tick), 8'h00);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("first_tick",  8'(p_tick),  8'h01);
        check("first_digit", 8'(p_digit), 8'h01);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("first_segs",  8'(p_segments), 8'h06);
        repeat (31) step(1'b1, 1'b1, 1'b0, 4'd0);
        check("ninth_digit", 8'(p_digit), 8'h09);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("ninth_segs",  8'(p_segments), 8'h6F);

        // 3. Up wrap 9 -> 0, then a non-wrapping 0 -> 1.
        repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);
        check("upwrap_digit", 8'(p_digit), 8'h00);
        check("upwrap_wrap",  8'(p_wrap),  8'h01);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("upwrap_pulse", 8'(p_wrap),     8'h00);
        check("upwrap_segs",  8'(p_segments), 8'h3F);
        repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);
        check("zero_one_digit", 8'(p_digit), 8'h01);
        check("zero_one_wrap",  8'(p_wrap),  8'h00);

        // 4. Down: 1 -> 0 (no wrap), 0 -> 9 (wrap), 9 -> 8.
        repeat (4) step(1'b1, 1'b0, 1'b0, 4'd0);
        check("down_zero_wrap", 8'(p_wrap), 8'h00);
        repeat (4) step(1'b1, 1'b0, 1'b0, 4'd0);
        check("dnwrap_digit", 8'(p_digit), 8'h09);
        check("dnwrap_wrap",  8'(p_wrap),  8'h01);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("dnwrap_segs",  8'(p_segments), 8'h6F);
        repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0);
        check("nine_eight_digit", 8'(p_digit), 8'h08);
        check("nine_eight_wrap",  8'(p_wrap),  8'h00);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("nine_eight_segs",  8'(p_segments), 8'h7F);

        // 5. Load on the terminal cycle suppresses the step and restarts the period.
        repeat (2) step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b1, 4'd7);
        check("load_digit", 8'(p_digit), 8'h07);
        check("load_tick",  8'(p_tick),  8'h00);
        repeat (4) step(1'b1, 1'b1, 1'b0, 4'd0);
        check("post_load_tick",  8'(p_tick),  8'h01);
        check("post_load_digit", 8'(p_digit), 8'h08);
        step(1'b1, 1'b1, 1'b1, 4'd12);
        check("load_clamp", 8'(p_digit), 8'h09);
        step(1'b0, 1'b1, 1'b1, 4'd3);
        check("load_disabled", 8'(p_digit), 8'h03);

        // 6. Asynchronous reset mid-period, then a full first period.
        step(1'b1, 1'b1, 1'b1, 4'd5);
        repeat (2) step(1'b1, 1'b1, 1'b0, 4'd0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_digit",  8'(p_digit),    8'h00);
        check("midrst_segs",   8'(p_segments), 8'h3F);
        check("midrst_n_segs", 8'(n_segments), 8'h40);
        #1 rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("postrst_tick",  8'(p_tick),  8'h01);
        check("postrst_digit", 8'(p_digit), 8'h01);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("n_segs_one", 8'(n_segments), 8'h79);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/seg7_tick_counter.md
Name: seg7_tick_counter

Overview:
Prescaled single-digit decimal up/down counter with a registered seven-segment encoder. It sits directly upstream of the top-level segment outputs (uo_out[6:0]) and produces the 7-bit pattern the segment bench checks. Control comes from ui_in bits (enable, direction, load); status pulses are exported for observation.

Parameters:
TICK_DIV, 10_000_000, clock cycles per count step (1 Hz at 10 MHz); legal range >= 2.
MAX_DIGIT, 9, highest digit value; the counter wraps between 0 and MAX_DIGIT; legal range 1..9.
SEG_ACTIVE_HIGH, 1, 1 = lit segment is 1; 0 = all segment bits inverted.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = prescaler runs; 0 = prescaler and digit hold
up_down  in  1  1 = count up, 0 = count down
load  in  1  synchronous load strobe, level-sampled each cycle
load_val  in  4  value loaded when load=1
digit  out  4  current digit value, registered
segments  out  7  segment pattern for digit, registered; bit0=a … bit6=g
tick  out  1  one-cycle pulse on each count step
wrap  out  1  one-cycle pulse when a step wraps (MAX_DIGIT->0 up, 0->MAX_DIGIT down)

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset state (async, immediate, independent of clk):
  - prescaler=0, digit=0, tick=0, wrap=0.
  - segments = encoding of 0 (7'h3F when SEG_ACTIVE_HIGH=1, 7'h40 when 0).
- Prescaler:
  - Width is $clog2(TICK_DIV).
  - Increments each cycle with enable=1 and load=0.
  - Terminal edge: enable=1, load=0 and prescaler==TICK_DIV-1. On that edge: prescaler<=0, tick<=1, digit<=next.
  - tick is 0 on every other edge.
- Step period: with enable held high, tick is high one cycle in every TICK_DIV.
- Next digit:
  - Up: digit==MAX_DIGIT -> 0, else +1.
  - Down: digit==0 -> MAX_DIGIT, else -1.
  - wrap<=1 on the same edge as the wrapping step, otherwise 0.
- Latency:
  - digit, tick and wrap update on the same edge.
  - segments update one edge later (registered lookup of the registered digit).
- Encoding (active-high, gfedcba):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Any digit > MAX_DIGIT is unreachable; if it ever occurs, encode as 7'h40 (dash).
  - SEG_ACTIVE_HIGH=0 inverts all 7 bits.
- Load (highest priority over stepping):
  - digit <= min(load_val, MAX_DIGIT). prescaler<=0. tick=0 and wrap=0 on that edge.
  - A load coincident with the terminal count suppresses the step.
  - load acts regardless of enable.
- enable=0: prescaler, digit and segments hold; tick and wrap are 0.
- up_down is sampled only at the terminal edge. Changing it mid-period affects the next step only.
- Reset asserted mid-period: everything clears immediately. After release, the first tick occurs TICK_DIV enabled cycles later; there is no partial period.
- No combinational path from any input to any output.

Decomposition:
- Package seg7_pkg holds:
  - SEG7_LUT constant (10 entries plus dash pattern 7'h40).
  - SEG_BLANK constant.
  - Function seg7_encode(digit, active_high) shared with future multi-digit blocks.
- Sub-module seg7_prescaler (counter plus terminal-tick generation, parameterised by TICK_DIV). It is reused by later display-scan blocks.
- The digit register and segment register stay in the top module.

Test Plan (TICK_DIV=4, MAX_DIGIT=9, SEG_ACTIVE_HIGH=1 unless stated):
1. Assert rst_n=0 with clk stopped -> digit=0, segments=7'h3F, tick=0, wrap=0 immediately. Release and hold enable=0 for 20 cycles -> all outputs unchanged.
2. enable=1, up_down=1 from reset -> tick on the 4th edge with digit=1, segments=7'h06 one edge later. Ticks every 4 cycles; the 9th step gives digit=9, segments=7'h6F.
3. Continue counting up from digit 9 -> next step gives digit=0 and wrap=1 for exactly one cycle, then segments=7'h3F. No wrap on the 0->1 step.
4. Down from digit 0 -> digit=9, wrap=1, segments=7'h6F. Then 9->8 gives segments=7'h7F with wrap=0.
5. Load: load=1, load_val=7 on the terminal cycle -> digit=7, tick=0, prescaler restarts, next tick 4 cycles later. load_val=12 -> digit=9. load with enable=0 -> digit updates.
6. Async reset mid-period (prescaler=2, digit=5) -> immediate clear. After release, first tick after exactly 4 enabled cycles. With SEG_ACTIVE_HIGH=0 instance: reset segments=7'h40, digit 1 -> 7'h79.
